// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment patterns and
// counter width helpers.
package bcd_disp_pkg;

    // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry d holds the active-low pattern for decimal digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    // Drive value for the segment and decimal-point pins of one digit.
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
    } seg_drive_t;

    localparam seg_drive_t DRIVE_OFF = '{seg: SEG_BLANK, dp: 1'b1};

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic digit_is_invalid(input logic [3:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 decode to blank.
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        pattern = SEG_BLANK;
        if (!digit_is_invalid(digit))
            pattern = SEG_TABLE[digit];
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver with leading-zero blanking,
// per-digit blink, anti-ghost slot blanking and invalid-code flagging.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GHOST_CYC   = 8,
    parameter int BLINK_SCANS = 64,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    lz_blank_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    invalid
);

    localparam int SLOT_W  = cnt_width(REFRESH_DIV);
    localparam int IDX_W   = cnt_width(NUM_DIGITS);
    localparam int BLINK_W = cnt_width(BLINK_SCANS);

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]     GHOST_END  = SLOT_W'(GHOST_CYC);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_SCANS - 1);
    // XOR mask that turns a one-hot enable into pin polarity; also the idle level.
    localparam logic [NUM_DIGITS-1:0] AN_IDLE    = {NUM_DIGITS{AN_ACT_LOW != 0}};

    logic [4*NUM_DIGITS-1:0] snapshot;
    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    phase;

    logic                    slot_end;
    logic                    scan_end;
    logic                    bcd_in_invalid;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_pattern;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_hot;
    seg_drive_t              drive_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign slot_end = (slot_cnt == SLOT_LAST);
    assign scan_end = slot_end && (idx == IDX_LAST);

    always_comb begin
        bcd_in_invalid = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            bcd_in_invalid = bcd_in_invalid | digit_is_invalid(bcd_in[4*k +: 4]);
    end

    // Reset release is expected to be synchronous to clk at the board level.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            snapshot <= '0;
            invalid  <= 1'b0;
        end else if (load) begin
            snapshot <= bcd_in;
            invalid  <= bcd_in_invalid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (slot_end) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (scan_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    assign cur_digit = snapshot[4*idx +: 4];

    bcd_seg_decode u_decode (
        .digit   (cur_digit),
        .pattern (cur_pattern)
    );

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        logic upper_zero;
        // NOTE: blocking assignments here chain the running flag through the loop within one evaluation.
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (snapshot[4*k +: 4] == 4'd0);
            lz_mask[k] = lz_blank_en && (k != 0) && upper_zero;
        end
    end

    assign an_hot = NUM_DIGITS'(1) << idx;

    // Priority: ghost window, then blink, then leading-zero blanking.
    always_comb begin
        drive_next.seg = cur_pattern;
        drive_next.dp  = ~dp_mask[idx];
        an_next        = an_hot ^ AN_IDLE;
        if (lz_mask[idx])
            drive_next.seg = SEG_BLANK;
        if (blink_mask[idx] && phase)
            drive_next = DRIVE_OFF;
        if (slot_cnt < GHOST_END) begin
            drive_next = DRIVE_OFF;
            an_next    = AN_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= AN_IDLE;
        end else begin
            seg <= drive_next.seg;
            dp  <= drive_next.dp;
            an  <= an_next;
        end
    end

endmodule
